stereo_matrix_ctrl: RTL and testbench

STEREO_MATRIX_CTRL -- requirements
Module: stereo_matrix_ctrl

---
 rtl/stereo_matrix_ctrl.sv | 169 ++++++++++++++++
 tb/tb_stereo_matrix_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_matrix_ctrl.sv
// -----------------------------------------------------------------------------
// stereo_matrix_ctrl
//
// Purpose:
//   Converts a mid/side style stereo stream into left/right channel samples.
//   One L+R word and one L-R word are popped together from two
//   first-word-fall-through FIFOs. The pair is turned into
//       left  = (L+R) + (L-R)   (= 2L)
//       right = (L+R) - (L-R)   (= 2R)
//   and then pushed together into two output FIFOs. A two-state FSM keeps the
//   read and write phases apart, so at most one pair is in flight.
//
// Ports:
//   clock        : single clock, all state updates on the rising edge
//   reset        : asynchronous, active-low reset
//   lpr_dout     : L+R sample (valid while lpr_empty is low)
//   lpr_empty    : L+R FIFO empty flag
//   lpr_rd_en    : L+R FIFO pop
//   lmr_dout     : L-R sample (valid while lmr_empty is low)
//   lmr_empty    : L-R FIFO empty flag
//   lmr_rd_en    : L-R FIFO pop
//   left_din     : registered 2L sample
//   left_wr_en   : left FIFO push
//   left_full    : left FIFO full flag
//   right_din    : registered 2R sample
//   right_wr_en  : right FIFO push
//   right_full   : right FIFO full flag
//   mono         : when high, the L-R sample is consumed but treated as zero
//   sample_count : number of stereo pairs pushed since reset (wraps)
//
// Configuration:
//   STEREO_MATRIX_SAT_EN : when defined, sum/difference overflow clamps to the
//                          most positive / most negative representable value.
//                          When undefined, results wrap modulo 2^DATA_WIDTH.
// -----------------------------------------------------------------------------
module stereo_matrix_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] lpr_dout,
    input  logic                  lpr_empty,
    output logic                  lpr_rd_en,

    input  logic [DATA_WIDTH-1:0] lmr_dout,
    input  logic                  lmr_empty,
    output logic                  lmr_rd_en,

    output logic [DATA_WIDTH-1:0] left_din,
    output logic                  left_wr_en,
    input  logic                  left_full,

    output logic [DATA_WIDTH-1:0] right_din,
    output logic                  right_wr_en,
    input  logic                  right_full,

    input  logic                  mono,
    output logic [31:0]           sample_count
);

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] left_q,  left_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;
    logic [31:0]           count_q, count_d;

    logic                  pop;
    logic                  push;
    logic [DATA_WIDTH-1:0] lmr_eff;
    logic [DATA_WIDTH-1:0] sum_res;
    logic [DATA_WIDTH-1:0] diff_res;

    // Mono mode still consumes the L-R word; it just contributes nothing.
    assign lmr_eff = mono ? '0 : lmr_dout;

`ifdef STEREO_MATRIX_SAT_EN
    // Saturating arithmetic: compute one bit wider, then clamp when the two
    // top bits disagree (the true result left the DATA_WIDTH signed range).
    logic [DATA_WIDTH:0] sum_ext;
    logic [DATA_WIDTH:0] diff_ext;

    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MAX_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        sum_ext  = {lpr_dout[DATA_WIDTH-1], lpr_dout} + {lmr_eff[DATA_WIDTH-1], lmr_eff};
        diff_ext = {lpr_dout[DATA_WIDTH-1], lpr_dout} - {lmr_eff[DATA_WIDTH-1], lmr_eff};

        if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
            sum_res = sum_ext[DATA_WIDTH] ? MAX_NEG : MAX_POS;
        end else begin
            sum_res = sum_ext[DATA_WIDTH-1:0];
        end

        if (diff_ext[DATA_WIDTH] != diff_ext[DATA_WIDTH-1]) begin
            diff_res = diff_ext[DATA_WIDTH] ? MAX_NEG : MAX_POS;
        end else begin
            diff_res = diff_ext[DATA_WIDTH-1:0];
        end
    end
`else
    // Plain two's complement: overflow simply wraps.
    assign sum_res  = lpr_dout + lmr_eff;
    assign diff_res = lpr_dout - lmr_eff;
`endif

    // Handshakes are gated by reset so that no FIFO is popped or pushed while
    // reset is held low, even though the state register already sits in
    // S_READ at that time.
    assign pop  = reset && (state_q == S_READ)  && !lpr_empty && !lmr_empty;
    assign push = reset && (state_q == S_WRITE) && !left_full && !right_full;

    assign lpr_rd_en    = pop;
    assign lmr_rd_en    = pop;
    assign left_wr_en   = push;
    assign right_wr_en  = push;
    assign left_din     = left_q;
    assign right_din    = right_q;
    assign sample_count = count_q;

    // Next-state logic: capture a new pair on a pop, hold it throughout the
    // write phase, and count each completed push.
    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        count_d = count_q;

        case (state_q)
            S_READ: begin
                if (pop) begin
                    left_d  = sum_res;
                    right_d = diff_res;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (push) begin
                    count_d = count_q + 32'd1;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_READ;
            end
        endcase
    end

    // State registers; reset discards any pair waiting to be written.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_READ;
            left_q  <= '0;
            right_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_stereo_matrix_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stereo_matrix_ctrl
//
// Purpose:
//   Self-checking bench for stereo_matrix_ctrl. Inputs are changed on the
//   falling clock edge and outputs sampled 1 time unit later. A behavioural
//   model (one "pair pending" flag plus the held pair and a counter) predicts
//   every handshake and output value.
// -----------------------------------------------------------------------------
module tb_stereo_matrix_ctrl;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] lpr_dout = '0;
    logic          lpr_empty = 1'b1;
    logic          lpr_rd_en;
    logic [DW-1:0] lmr_dout = '0;
    logic          lmr_empty = 1'b1;
    logic          lmr_rd_en;
    logic [DW-1:0] left_din;
    logic          left_wr_en;
    logic          left_full = 1'b0;
    logic [DW-1:0] right_din;
    logic          right_wr_en;
    logic          right_full = 1'b0;
    logic          mono = 1'b0;
    logic [31:0]   sample_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_pending = 1'b0;
    logic [DW-1:0] m_left  = '0;
    logic [DW-1:0] m_right = '0;
    logic [31:0]   m_count = '0;

    stereo_matrix_ctrl #(.DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .lpr_dout     (lpr_dout),
        .lpr_empty    (lpr_empty),
        .lpr_rd_en    (lpr_rd_en),
        .lmr_dout     (lmr_dout),
        .lmr_empty    (lmr_empty),
        .lmr_rd_en    (lmr_rd_en),
        .left_din     (left_din),
        .left_wr_en   (left_wr_en),
        .left_full    (left_full),
        .right_din    (right_din),
        .right_wr_en  (right_wr_en),
        .right_full   (right_full),
        .mono         (mono),
        .sample_count (sample_count)
    );

    always #5 clock = ~clock;

    // Mathematical sum/difference of two signed samples, then either clamped
    // to the signed range or reduced modulo 2^32.
    function automatic logic [DW-1:0] modelMix(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input bit subtract);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = subtract ? (sa - sb) : (sa + sb);
`ifdef STEREO_MATRIX_SAT_EN
        if (r > 64'sd2147483647)  r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
        return r[DW-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit lprE, input bit lmrE,
                                 input bit lFull, input bit rFull, input bit monoV,
                                 input logic [DW-1:0] lprV, input logic [DW-1:0] lmrV);
        lpr_empty  = lprE;
        lmr_empty  = lmrE;
        left_full  = lFull;
        right_full = rFull;
        mono       = monoV;
        lpr_dout   = lprV;
        lmr_dout   = lmrV;
    endtask

    // Called at a falling edge after inputs are set: checks handshakes and
    // registered outputs, advances the model, then waits for the next fall.
    task automatic runCycle(input string tag);
        bit expRd;
        bit expWr;
        #1;
        if (!reset) begin
            m_pending = 1'b0;
            m_left    = '0;
            m_right   = '0;
            m_count   = '0;
        end
        expRd = reset && !m_pending && !lpr_empty && !lmr_empty;
        expWr = reset &&  m_pending && !left_full && !right_full;
        checkOutput({tag, ".lpr_rd_en"},   lpr_rd_en,   expRd);
        checkOutput({tag, ".lmr_rd_en"},   lmr_rd_en,   expRd);
        checkOutput({tag, ".left_wr_en"},  left_wr_en,  expWr);
        checkOutput({tag, ".right_wr_en"}, right_wr_en, expWr);
        checkOutput({tag, ".left_din"},    left_din,    m_left);
        checkOutput({tag, ".right_din"},   right_din,   m_right);
        checkOutput({tag, ".count"},       sample_count, m_count);
        if (expRd) begin
            m_pending = 1'b1;
            m_left    = modelMix(lpr_dout, mono ? '0 : lmr_dout, 1'b0);
            m_right   = modelMix(lpr_dout, mono ? '0 : lmr_dout, 1'b1);
        end
        if (expWr) begin
            m_pending = 1'b0;
            m_count   = m_count + 32'd1;
        end
        @(negedge clock);
    endtask

    initial begin
        $display("[TB] start");
        #2 reset = 1'b0;
        @(negedge clock);

        // Reset state, including FIFOs offering data while reset is low.
        applyStimulus(1, 1, 0, 0, 0, '0, '0);
        runCycle("reset_idle");
        applyStimulus(0, 0, 0, 0, 0, 32'd5, 32'd6);
        runCycle("reset_no_pop");
        checkOutput("reset_left_zero", left_din, 32'd0);
        reset = 1'b1;

        // Basic pair: 100, 30 -> 130 / 70, push next cycle, count 1.
        applyStimulus(0, 0, 0, 0, 0, 32'd100, 32'd30);
        runCycle("basic_pop");
        applyStimulus(1, 1, 0, 0, 0, '0, '0);
        runCycle("basic_push");
        checkOutput("basic_left_130",  left_din,  32'd130);
        checkOutput("basic_right_70",  right_din, 32'd70);
        checkOutput("basic_count_1",   sample_count, 32'd1);

        // Positive overflow on the sum only.
        applyStimulus(0, 0, 0, 0, 0, 32'h7FFF_FFF0, 32'h0000_0020);
        runCycle("ovf_pop");
        applyStimulus(1, 1, 0, 0, 0, '0, '0);
        runCycle("ovf_push");
`ifdef STEREO_MATRIX_SAT_EN
        checkOutput("ovf_left_sat",  left_din,  32'h7FFF_FFFF);
`else
        checkOutput("ovf_left_wrap", left_din,  32'h8000_0010);
`endif
        checkOutput("ovf_right",     right_din, 32'h7FFF_FFD0);

        // L-R FIFO empty for 10 cycles: no pop until it fills.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 32'd7, 32'd1234);
            runCycle("lmr_empty_stall");
        end
        applyStimulus(0, 0, 0, 0, 0, 32'd7, 32'd3);
        runCycle("lmr_fill_pop");
        applyStimulus(1, 1, 0, 0, 0, '0, '0);
        runCycle("lmr_fill_push");

        // Right FIFO full for 20 cycles after a pop.
        applyStimulus(0, 0, 0, 1, 0, 32'hFFFF_FF00, 32'd16);
        runCycle("rfull_pop");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 32'd1, 32'd1);
            runCycle("rfull_stall");
        end
        checkOutput("rfull_left_held", left_din, 32'hFFFF_FF10);
        applyStimulus(1, 1, 0, 0, 0, '0, '0);
        runCycle("rfull_push");
        runCycle("rfull_after");
        checkOutput("rfull_count_4", sample_count, 32'd4);

        // Mono: -50 with lmr=999 ignored, but still popped.
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFCE, 32'd999);
        runCycle("mono_pop");
        applyStimulus(1, 1, 0, 0, 0, '0, '0);
        runCycle("mono_push");
        checkOutput("mono_left",  left_din,  32'hFFFF_FFCE);
        checkOutput("mono_right", right_din, 32'hFFFF_FFCE);

        // Reset during a write stall discards the held pair.
        applyStimulus(0, 0, 1, 0, 0, 32'd11, 32'd22);
        runCycle("rst_pop");
        applyStimulus(1, 1, 1, 0, 0, '0, '0);
        runCycle("rst_stall");
        runCycle("rst_stall");
        reset = 1'b0;
        applyStimulus(1, 1, 0, 0, 0, '0, '0);
        runCycle("rst_low");
        checkOutput("rst_count_zero", sample_count, 32'd0);
        reset = 1'b1;
        runCycle("rst_release_idle");
        applyStimulus(0, 0, 0, 0, 0, 32'd40, 32'd2);
        runCycle("rst_first_pop");
        applyStimulus(1, 1, 0, 0, 0, '0, '0);
        runCycle("rst_first_push");

        // Randomised traffic with biased boundary values.
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = {1'b0, {(DW-1){1'b1}}} - $urandom_range(0, 64);
            if ($urandom_range(0, 3) == 0) b = {1'b1, {(DW-1){1'b0}}} + $urandom_range(0, 64);
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) == 0, a, b);
            runCycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
